// File: rtl/ordenador_pkg.sv
// ---------------------------------------------------------------------------
// ordenador_pkg
// Shared definitions for the bubble sorter ordenador_bolha:
//   - estado_t : FSM state encoding (OCIOSO, COMPARA, FIM)
//   - N        : number of elements sorted (4)
//   - LARG     : element width in bits (4)
//   - PASSES   : number of bubble passes in the worst case (N-1)
//   - condicao_troca() : decides whether a compared pair must be exchanged
// ---------------------------------------------------------------------------
package ordenador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        COMPARA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam int N      = 4;
    localparam int LARG   = 4;
    localparam int PASSES = N - 1;

    // Equal elements never swap, which keeps the sort stable regardless of
    // the direction selected.
    function automatic logic condicao_troca(input logic desc,
                                            input logic agtb,
                                            input logic altb,
                                            input logic aeqb);
        return !aeqb && (desc ? altb : agtb);
    endfunction

endpackage

// File: rtl/ComparadorMagnitude.sv
// ---------------------------------------------------------------------------
// ComparadorMagnitude
// Purely combinational unsigned magnitude comparator.
// Ports:
//   a, b  : operands, W bits each
//   agtb  : a >  b
//   aeqb  : a == b
//   altb  : a <  b
// Exactly one of the three outputs is high at any time.
// ---------------------------------------------------------------------------
module ComparadorMagnitude #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         agtb,
    output logic         aeqb,
    output logic         altb
);

    assign agtb = (a >  b);
    assign aeqb = (a == b);
    assign altb = (a <  b);

endmodule

// File: rtl/ordenador_bolha.sv
// ---------------------------------------------------------------------------
// ordenador_bolha
// Sequential bubble sorter for four 4-bit elements using a single shared
// magnitude comparator. One pair (j, j+1) is compared per COMPARA cycle;
// a pass without any exchange ends the sort early.
// Parameter:
//   ORDEM      : 0 = ascending, 1 = descending
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (priority over start)
//   start      : sort request, only honoured in OCIOSO
//   dados_in   : four packed elements, element k in [4k+3:4k]
//   busy       : high in COMPARA and FIM
//   done       : one-cycle pulse in FIM; dados_out/num_trocas are final
//   dados_out  : working registers r0..r3, same packing as dados_in
//   num_trocas : exchanges performed by the current or last sort (0..6)
// ---------------------------------------------------------------------------
module ordenador_bolha
    import ordenador_pkg::*;
#(
    parameter int ORDEM = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*LARG-1:0]   dados_in,
    output logic                busy,
    output logic                done,
    output logic [N*LARG-1:0]   dados_out,
    output logic [2:0]          num_trocas
);

    estado_t           estado;
    logic [LARG-1:0]   r [N];
    logic [1:0]        p;          // current pass
    logic [1:0]        j;          // left position of the compared pair
    logic              houve_troca; // any exchange so far in this pass

    logic [1:0]        j_prox;
    logic [1:0]        ultimo_j;
    logic [LARG-1:0]   a_cmp;
    logic [LARG-1:0]   b_cmp;
    logic              agtb;
    logic              aeqb;
    logic              altb;
    logic              troca;
    logic              fim_passo;
    logic              ultimo_passo;

    // Pair selection for the shared comparator.
    assign j_prox   = j + 2'd1;
    assign a_cmp    = r[j];
    assign b_cmp    = r[j_prox];

    ComparadorMagnitude #(
        .W(LARG)
    ) u_comparador (
        .a    (a_cmp),
        .b    (b_cmp),
        .agtb (agtb),
        .aeqb (aeqb),
        .altb (altb)
    );

    assign troca        = condicao_troca(ORDEM != 0, agtb, altb, aeqb);
    // Pass p compares positions 0 .. N-2-p; later positions are already final.
    assign ultimo_j     = 2'(PASSES - 1) - p;
    assign fim_passo    = (j == ultimo_j);
    assign ultimo_passo = (p == 2'(PASSES - 1));

    always_comb begin
        dados_out = '0;
        for (int k = 0; k < N; k++) begin
            dados_out[k*LARG +: LARG] = r[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= OCIOSO;
            for (int k = 0; k < N; k++) begin
                r[k] <= '0;
            end
            num_trocas  <= '0;
            p           <= '0;
            j           <= '0;
            houve_troca <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < N; k++) begin
                            r[k] <= dados_in[k*LARG +: LARG];
                        end
                        num_trocas  <= '0;
                        p           <= '0;
                        j           <= '0;
                        houve_troca <= 1'b0;
                        busy        <= 1'b1;
                        estado      <= COMPARA;
                    end
                end

                COMPARA: begin
                    if (troca) begin
                        r[j]       <= b_cmp;
                        r[j_prox]  <= a_cmp;
                        num_trocas <= num_trocas + 3'd1;
                    end
                    if (fim_passo) begin
                        // The exchange made on this very edge counts towards
                        // the decision, hence the OR with troca.
                        if (!(houve_troca || troca) || ultimo_passo) begin
                            estado <= FIM;
                            done   <= 1'b1;
                        end else begin
                            p           <= p + 2'd1;
                            j           <= '0;
                            houve_troca <= 1'b0;
                        end
                    end else begin
                        j           <= j_prox;
                        houve_troca <= houve_troca | troca;
                    end
                end

                FIM: begin
                    estado <= OCIOSO;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end

                default: begin
                    estado <= OCIOSO;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ordenador_bolha.sv
// ---------------------------------------------------------------------------
// tb_ordenador_bolha
// Directed bench for ordenador_bolha: one ascending instance (ORDEM=0) and
// one descending instance (ORDEM=1) sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_ordenador_bolha;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] din0 = '0, din1 = '0;
    logic        busy0, busy1, done0, done1;
    logic [15:0] out0, out1;
    logic [2:0]  tr0, tr1;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ordenador_bolha #(.ORDEM(0)) dut_asc (
        .clk(clk), .rst(rst), .start(start0), .dados_in(din0),
        .busy(busy0), .done(done0), .dados_out(out0), .num_trocas(tr0)
    );

    ordenador_bolha #(.ORDEM(1)) dut_desc (
        .clk(clk), .rst(rst), .start(start1), .dados_in(din1),
        .busy(busy1), .done(done1), .dados_out(out1), .num_trocas(tr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    // Launches one sort, follows it cycle by cycle (cycle 1 = the cycle after
    // the accepting edge) and checks result, done timing, busy length and
    // that the result holds afterwards.
    task automatic run_sort(input string tag, input bit sel, input logic [15:0] din,
                            input logic [15:0] exp_out, input logic [2:0] exp_tr,
                            input int exp_done, input bit repulse);
        int first = 0;
        int ndone = 0;
        int nbusy = 0;
        logic b, d;
        @(negedge clk);
        if (sel) din1 = din; else din0 = din;
        set_start(sel, 1'b1);
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) set_start(sel, 1'b0);
            if (repulse && c == 2) begin
                if (sel) din1 = 16'h1111; else din0 = 16'h1111;
                set_start(sel, 1'b1);
            end
            if (repulse && c == 3) set_start(sel, 1'b0);
            b = sel ? busy1 : busy0;
            d = sel ? done1 : done0;
            if (b) nbusy++;
            if (d) begin
                ndone++;
                if (first == 0) begin
                    first = c;
                    chk({tag, ".out_at_done"}, sel ? out1 : out0, exp_out);
                    chk({tag, ".trocas_at_done"}, sel ? tr1 : tr0, exp_tr);
                end
            end
            if (!b) break;
        end
        chk({tag, ".done_cycle"}, first, exp_done);
        chk({tag, ".done_pulses"}, ndone, 1);
        chk({tag, ".busy_cycles"}, nbusy, exp_done);
        repeat (2) @(negedge clk);
        chk({tag, ".out_held"}, sel ? out1 : out0, exp_out);
        chk({tag, ".trocas_held"}, sel ? tr1 : tr0, exp_tr);
        chk({tag, ".idle_busy"}, sel ? busy1 : busy0, 0);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy0", busy0, 0);
        chk("rst.done0", done0, 0);
        chk("rst.out0", out0, 16'h0000);
        chk("rst.tr0", tr0, 0);
        chk("rst.busy1", busy1, 0);
        chk("rst.out1", out1, 16'h0000);
        rst = 1'b0;

        // Ascending: {5,10,12,3} -> {3,5,10,12}, 3 swaps, 6 comparisons
        run_sort("asc_mix", 1'b0, 16'h3CA5, 16'hCA53, 3'd3, 7, 1'b0);
        // Already sorted: early exit after 3 comparisons
        run_sort("asc_sorted", 1'b0, 16'h4321, 16'h4321, 3'd0, 4, 1'b0);
        // Reverse order: 6 swaps
        run_sort("asc_reverse", 1'b0, 16'h5ACF, 16'hFCA5, 3'd6, 7, 1'b0);
        // All equal: never swap
        run_sort("asc_equal", 1'b0, 16'hCCCC, 16'hCCCC, 3'd0, 4, 1'b0);
        // Descending with a second start pulsed while busy
        run_sort("desc_mix", 1'b1, 16'h3CA5, 16'h35AC, 3'd3, 7, 1'b1);

        // Start held high: relaunch on first OCIOSO cycle after FIM
        @(negedge clk);
        din0 = 16'h4321;
        start0 = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        chk("hold.done_c4", done0, 1);
        @(negedge clk);
        chk("hold.idle_c5", busy0, 0);
        @(negedge clk);
        chk("hold.relaunch_c6", busy0, 1);
        start0 = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0) seen++;
            if (!busy0) break;
        end
        chk("hold.second_done", seen, 1);

        // Reset in the 3rd COMPARA cycle of {15,12,10,5}
        @(negedge clk);
        din0 = 16'h5ACF;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst.busy_before", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.busy", busy0, 0);
        chk("midrst.done", done0, 0);
        chk("midrst.out", out0, 16'h0000);
        chk("midrst.tr", tr0, 0);
        rst = 1'b0;
        run_sort("after_rst", 1'b0, 16'h3CA5, 16'hCA53, 3'd3, 7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
